// File: rtl/mux_n_1_reg_pkg.sv
// Shared definitions for mux_n_1_reg: output-stage FSM encoding, default sizes,
// and a clog2 helper for tools lacking $clog2.
package mux_n_1_reg_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } mux_state_e;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_n_1_reg_scan_ctr.sv
// mux_scan_ctr: mod-N channel scan pointer; advances on i_en, wraps N-1 -> 0.
module mux_scan_ctr #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic [SW-1:0] o_cnt
);

  logic [SW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                       r_cnt <= '0;
    else if (i_en) begin
      if (r_cnt == SW'(N - 1))       r_cnt <= '0;
      else                           r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mux_n_1_reg.sv
// N:1, W-bit mux with a single registered valid/ready output slot and manual or
// auto-scan channel select. Define MUX_PARITY_EN to add the registered parity port P.
module mux_n_1_reg
  import mux_n_1_reg_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int W  = DEF_W,
  localparam int SW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N*W-1:0] D,
  input  logic [SW-1:0]  S,
  input  logic           SCAN,
  input  logic           IN_VALID,
  output logic           IN_READY,
  output logic [W-1:0]   F,
  output logic [SW-1:0]  SEL_OUT,
  output logic           ERR,
  output logic           OUT_VALID,
`ifdef MUX_PARITY_EN
  output logic           P,
`endif
  input  logic           OUT_READY
);

  mux_state_e r_state, w_state_nxt;

  logic [N-1:0][W-1:0] w_ch;
  logic [SW-1:0]       w_ptr, w_sel;
  logic [W-1:0]        w_data;
  logic                w_hit, w_accept, w_pop;
  logic [W-1:0]        r_f;
  logic [SW-1:0]       r_sel;
  logic                r_err;

  assign w_ch      = D;
  assign OUT_VALID = (r_state == ST_FULL);
  assign IN_READY  = !OUT_VALID || OUT_READY;
  assign w_accept  = IN_VALID && IN_READY;
  assign w_pop     = OUT_VALID && OUT_READY;
  assign w_sel     = SCAN ? w_ptr : S;

  mux_scan_ctr #(.N(N), .SW(SW)) u_scan (
    .i_clk (CLK),
    .i_rst (RST),
    .i_en  (w_accept && SCAN),
    .o_cnt (w_ptr)
  );

  // Compare-per-channel avoids indexing past N when N is not a power of two.
  always_comb begin
    w_data = '0;
    w_hit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (w_sel == SW'(k)) begin
        w_data = w_ch[k];
        w_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_accept) w_state_nxt = ST_FULL;
                else if (w_pop) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_f   <= '0;
      r_sel <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_f   <= w_data;
      r_sel <= w_sel;
      r_err <= !w_hit;
    end
  end

  assign F       = r_f;
  assign SEL_OUT = r_sel;
  assign ERR     = r_err;

`ifdef MUX_PARITY_EN
  logic r_p;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_p <= 1'b0;
    else if (w_accept) r_p <= ^w_data;
  end
  assign P = r_p;
`endif

endmodule
